// File: rtl/fetch_stage.sv
// Instruction fetch with IF/ID register: one outstanding imem request, word lands in IF/ID the edge after rvalid.
// Latency: 2 cycles per instruction with single-cycle memory. Backpressure: stall holds IF/ID and parks a late word in a 1-entry buffer.
module fetch_stage #(
    parameter int                XLEN     = 32,
    parameter logic [XLEN-1:0]   RESET_PC = '0,
    parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     id_inst,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_pc4,
    output logic [6:0]      opcode,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic            bubble
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_inflight_q, pc_inflight_d;
    logic            kill_q, kill_d;
    logic [31:0]     buf_inst_q, buf_inst_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [31:0]     id_inst_q, id_inst_d;
    logic [XLEN-1:0] id_pc_q, id_pc_d;
    logic            bubble_q, bubble_d;

    logic            new_vld;
    logic [31:0]     new_inst;
    logic [XLEN-1:0] new_pc;

    logic            unused_rpc_bits;
    assign unused_rpc_bits = ^redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        kill_d        = kill_q;
        buf_inst_d    = buf_inst_q;
        buf_pc_d      = buf_pc_q;
        new_vld       = 1'b0;
        new_inst      = NOP_INST;
        new_pc        = id_pc_q;

        case (state_q)
            S_FETCH: begin
                if (imem_gnt) begin
                    pc_inflight_d = pc_q;
                    pc_d          = pc_q + XLEN'(4);
                    state_d       = S_WAIT;
                    kill_d        = redirect;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_d = S_FETCH;
                    kill_d  = 1'b0;
                    // A killed or same-cycle-redirected response is simply dropped.
                    if (!kill_q && !redirect) begin
                        if (!stall) begin
                            new_vld  = 1'b1;
                            new_inst = imem_rdata;
                            new_pc   = pc_inflight_q;
                        end else begin
                            buf_inst_d = imem_rdata;
                            buf_pc_d   = pc_inflight_q;
                            state_d    = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    kill_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    state_d = S_FETCH;
                end else if (!stall) begin
                    new_vld  = 1'b1;
                    new_inst = buf_inst_q;
                    new_pc   = buf_pc_q;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase

        if (redirect) begin
            pc_d = {redirect_pc[XLEN-1:2], 2'b00};
        end
    end

    always_comb begin
        id_inst_d = id_inst_q;
        id_pc_d   = id_pc_q;
        bubble_d  = bubble_q;
        if (redirect) begin
            id_inst_d = NOP_INST;
            bubble_d  = 1'b1;
        end else if (stall) begin
            id_inst_d = id_inst_q;
        end else if (new_vld) begin
            id_inst_d = new_inst;
            id_pc_d   = new_pc;
            bubble_d  = 1'b0;
        end else begin
            id_inst_d = NOP_INST;
            bubble_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            pc_inflight_q <= '0;
            kill_q        <= 1'b0;
            buf_inst_q    <= NOP_INST;
            buf_pc_q      <= '0;
            id_inst_q     <= NOP_INST;
            id_pc_q       <= '0;
            bubble_q      <= 1'b1;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
            kill_q        <= kill_d;
            buf_inst_q    <= buf_inst_d;
            buf_pc_q      <= buf_pc_d;
            id_inst_q     <= id_inst_d;
            id_pc_q       <= id_pc_d;
            bubble_q      <= bubble_d;
        end
    end

    assign imem_req  = (state_q == S_FETCH) && !reset;
    assign imem_addr = pc_q;

    assign id_inst = id_inst_q;
    assign id_pc   = id_pc_q;
    assign id_pc4  = id_pc_q + XLEN'(4);
    assign bubble  = bubble_q;
    assign opcode  = id_inst_q[6:0];
    assign rd      = id_inst_q[11:7];
    assign func3   = id_inst_q[14:12];
    assign rs1     = id_inst_q[19:15];
    assign rs2     = id_inst_q[24:20];
    assign func7   = id_inst_q[31:25];

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register; sits directly upstream of the decode controller.
- Owns the PC, runs a single-outstanding-request handshake to instruction memory, and latches the returned word with its PC.
- Presents opcode/func3/func7/register fields and the `bubble` flag to decode.
- Handles stall (hold) and redirect (flush + new PC) from later stages.

Parameters:
- XLEN, 32, datapath/PC width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, instruction word (addi x0,x0,0) driven into IF/ID when empty or flushed.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request valid.
- imem_addr  output  XLEN  fetch address (word aligned).
- imem_gnt  input  1  request accepted this cycle (sampled only while imem_req=1).
- imem_rvalid  input  1  read data valid, at least 1 cycle after grant.
- imem_rdata  input  32  returned instruction.
- stall  input  1  hold IF/ID contents (load-use or downstream busy).
- redirect  input  1  taken branch/jump: flush and refetch.
- redirect_pc  input  XLEN  new PC; bits [1:0] ignored (treated as 0).
- id_inst  output  32  IF/ID instruction word.
- id_pc  output  XLEN  PC of id_inst.
- id_pc4  output  XLEN  id_pc+4, modulo 2^XLEN.
- opcode  output  7  id_inst[6:0].
- func3  output  3  id_inst[14:12].
- func7  output  7  id_inst[31:25].
- rd  output  5  id_inst[11:7].
- rs1  output  5  id_inst[19:15].
- rs2  output  5  id_inst[24:20].
- bubble  output  1  1 = IF/ID holds no valid instruction.

Behaviour:
- Reset (async assert):
  - pc=RESET_PC; state=FETCH; kill=0; buffer empty.
  - id_inst=NOP_INST; id_pc=0; bubble=1.
  - imem_req=0 while reset is asserted.
- Field outputs are combinational slices of id_inst. id_pc4 is combinational.
- FETCH state:
  - Drive imem_req=1 and imem_addr=pc.
  - On imem_gnt: pc_inflight<=pc; pc<=pc+4 (wraps at 2^XLEN); go to WAIT.
- WAIT state:
  - Drive imem_req=0.
  - On imem_rvalid with kill=1: discard data, clear kill, go to FETCH.
  - On imem_rvalid, kill=0, stall=0: load IF/ID (id_inst<=rdata, id_pc<=pc_inflight, bubble<=0); go to FETCH.
  - On imem_rvalid, kill=0, stall=1: capture rdata and pc_inflight in the 1-entry buffer; go to HOLD.
- HOLD state:
  - Drive imem_req=0.
  - When stall=0: load IF/ID from the buffer, bubble<=0; go to FETCH.
- IF/ID update priority each cycle: redirect > stall > new word > empty.
  - redirect: id_inst<=NOP_INST, bubble<=1.
  - stall: hold all IF/ID contents.
  - new word (from rdata or buffer): load it.
  - no word available: id_inst<=NOP_INST, bubble<=1.
- Redirect handling (redirect=1 overrides stall):
  - pc<={redirect_pc[XLEN-1:2],2'b00}.
  - In FETCH with no grant: the next request uses the new pc in the following cycle.
  - In FETCH with grant in the same cycle: go to WAIT with kill=1. The pc update to redirect_pc wins over pc+4.
  - In WAIT without rvalid: set kill=1.
  - In WAIT with rvalid in the same cycle: drop the data; go to FETCH, kill=0.
  - In HOLD: discard the buffer; go to FETCH.
- Throughput: at most one request outstanding. With 1-cycle memory latency, one instruction every 2 cycles.
- Stall held indefinitely:
  - No data is lost.
  - No second request is issued while the buffer is full.
  - In FETCH, requests continue; the returning word goes to the buffer.
- imem_rvalid outside WAIT is ignored.
- imem_gnt outside FETCH is ignored.

Test Plan:
- Reset release, 1-cycle memory returning 32'h00500093 at addr 0:
  - imem_req=1, addr=0.
  - Two cycles later id_inst=32'h00500093, opcode=7'h13, rd=1, id_pc=0, id_pc4=4, bubble=0.
  - Next request addr=4.
- Stall asserted for 3 cycles while a response arrives:
  - IF/ID unchanged throughout.
  - The word is buffered; no imem_req during HOLD.
  - The cycle after stall drops, IF/ID holds the buffered word and its PC.
- Redirect to 32'h0000_0103 while in WAIT:
  - The response is discarded; bubble=1, id_inst=32'h00000013.
  - Next imem_addr=32'h0000_0100.
- Redirect and imem_gnt in the same FETCH cycle:
  - The granted word is killed; next request is to the redirect target.
  - No instruction from the old path ever reaches IF/ID.
- Redirect and stall both high:
  - Flush wins: bubble=1 next cycle, pc=redirect target.
- PC wrap, RESET_PC=32'hFFFF_FFFC:
  - First fetch addr=32'hFFFF_FFFC, second fetch addr=0.
  - id_pc4 of the first instruction = 0.
- Async reset mid-WAIT:
  - Immediately bubble=1, imem_req=0.
  - A late rvalid after release is ignored; fetch restarts at RESET_PC.
